shift_sequencer: RTL and testbench

- Upstream feeder for the 4-bit bidirectional shift register.
- Accepts a parallel word plus a direction and length over a valid/ready handshake.
- Serialises the word onto the register's serial inputs (d0/d1) and drives its mode select (sel) one bit per clock.
- Signals completion with a one-cycle done pulse, after which the register's q holds the word.

---
 rtl/shift_seq_pkg.sv | 20 ++
 rtl/shift_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_shift_sequencer.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/shift_seq_pkg.sv
// ---------------------------------------------------------------------------
// shift_seq_pkg
//   Shared definitions for the shift sequencer:
//   - sel encodings driven to the downstream bidirectional shift register
//   - sequencer FSM state enum
// ---------------------------------------------------------------------------
package shift_seq_pkg;

   // Mode select to the shift register. 2'b11 is never driven.
   localparam logic [1:0] SEL_HOLD = 2'b00;
   localparam logic [1:0] SEL_SHL  = 2'b01;   // shift left, serial in via d1
   localparam logic [1:0] SEL_SHR  = 2'b10;   // shift right, serial in via d0

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/shift_sequencer.sv
// ---------------------------------------------------------------------------
// shift_sequencer
//   Upstream feeder for a WIDTH-deep bidirectional shift register. Accepts a
//   parallel word + direction + length over valid/ready, then serialises it
//   one bit per clock onto d0 (right shift) or d1 (left shift) while driving
//   the register's sel. A one-cycle done pulse marks completion.
//
//   Optional feature (macro SHIFT_SEQ_PARITY_EN): after the data bits one
//   extra shift cycle carries the even parity (XOR) of the bits sent.
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-low reset
//   in_valid  in   request present
//   in_ready  out  request can be accepted (combinational)
//   in_data   in   [WIDTH] word to serialise
//   in_dir    in   0 = right via d0, 1 = left via d1
//   in_len    in   [CNT_W] bits to shift (clamped to WIDTH)
//   pause     in   freeze shifting while high
//   sel       out  [2] mode select to the shift register
//   d0, d1    out  serial data for right / left shift
//   busy      out  transfer in progress
//   done      out  one-cycle completion pulse
// ---------------------------------------------------------------------------
module shift_sequencer
   import shift_seq_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_dir,
   input  logic [CNT_W-1:0] in_len,
   input  logic             pause,
   output logic [1:0]       sel,
   output logic             d0,
   output logic             d1,
   output logic             busy,
   output logic             done
);

   // One extra bit of headroom so the parity slot (index len) and the index
   // arithmetic in pick_bit never wrap.
   localparam int PW = CNT_W + 1;

   state_t           state, state_n;
   logic [WIDTH-1:0] data_q, data_n;
   logic             dir_q, dir_n;
   logic [CNT_W-1:0] len_q, len_n;
   // Count of bits already taken by the shift register. A bit is taken on
   // every edge where sel is non-hold, so it advances on that edge even if
   // pause is high; pause only suppresses presenting the following bit.
   logic [PW-1:0]    pos, pos_n;

   logic             hs;
   logic [CNT_W-1:0] in_len_eff;
   logic [1:0]       sel_n;
   logic             d0_n, d1_n, busy_n, done_n;
   logic             nbit;

   assign in_ready   = (state == IDLE) && rst;
   assign hs         = in_valid && in_ready;
   assign in_len_eff = (in_len > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : in_len;

   // Number of shift cycles (data bits plus optional parity slot).
   function automatic logic [PW-1:0] total_bits(input logic [CNT_W-1:0] len);
`ifdef SHIFT_SEQ_PARITY_EN
      total_bits = PW'(len) + PW'(len != '0);
`else
      total_bits = PW'(len);
`endif
   endfunction

   // Serial bit for slot idx: right sends data[0] first, left sends
   // data[len-1] first; slot idx==len is the parity of the bits sent.
   function automatic logic pick_bit(input logic [WIDTH-1:0] data,
                                     input logic             dir,
                                     input logic [CNT_W-1:0] len,
                                     input logic [PW-1:0]    idx);
      logic par;
      par      = 1'b0;
      pick_bit = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         if (PW'(i) < PW'(len))
            par = par ^ data[i];
         if (!dir && (PW'(i) == idx))
            pick_bit = data[i];
         if (dir && ((PW'(i) + idx + PW'(1)) == PW'(len)))
            pick_bit = data[i];
      end
      if (idx == PW'(len))
         pick_bit = par;
   endfunction

   // ------------------------------------------------------------------
   // State and registered outputs
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         state  <= IDLE;
         pos    <= '0;
         data_q <= '0;
         dir_q  <= 1'b0;
         len_q  <= '0;
         sel    <= SEL_HOLD;
         d0     <= 1'b0;
         d1     <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         state  <= state_n;
         pos    <= pos_n;
         data_q <= data_n;
         dir_q  <= dir_n;
         len_q  <= len_n;
         sel    <= sel_n;
         d0     <= d0_n;
         d1     <= d1_n;
         busy   <= busy_n;
         done   <= done_n;
      end
   end

   // ------------------------------------------------------------------
   // Next state
   // ------------------------------------------------------------------
   always_comb begin
      state_n = state;
      pos_n   = pos;
      data_n  = data_q;
      dir_n   = dir_q;
      len_n   = len_q;
      case (state)
         IDLE: begin
            if (hs) begin
               data_n  = in_data;
               dir_n   = in_dir;
               len_n   = in_len_eff;
               pos_n   = '0;
               state_n = (in_len_eff == '0) ? DONE : SHIFT;
            end
         end
         SHIFT: begin
            pos_n = pos + PW'(sel != SEL_HOLD);
            // A pause on the final edge still costs one hold cycle before DONE.
            if (!pause && (pos_n == total_bits(len_q)))
               state_n = DONE;
         end
         DONE: begin
            state_n = IDLE;
            pos_n   = '0;
         end
         default: state_n = IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Next values of the registered outputs
   // ------------------------------------------------------------------
   always_comb begin
      sel_n  = SEL_HOLD;
      d0_n   = 1'b0;
      d1_n   = 1'b0;
      busy_n = 1'b0;
      done_n = 1'b0;
      nbit   = pick_bit(data_n, dir_n, len_n, pos_n);
      case (state_n)
         SHIFT: begin
            busy_n = 1'b1;
            if ((state == SHIFT) && pause) begin
               // Hold cycle: serial lines frozen, register not clocked.
               d0_n = d0;
               d1_n = d1;
            end else begin
               sel_n = dir_n ? SEL_SHL : SEL_SHR;
               if (dir_n) d1_n = nbit;
               else       d0_n = nbit;
            end
         end
         DONE:    done_n = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;

   localparam int WIDTH = 4;
   localparam int CNT_W = $clog2(WIDTH + 1);

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_dir;
   logic [CNT_W-1:0] in_len;
   logic             pause;
   logic [1:0]       sel;
   logic             d0, d1, busy, done;

   int tests;
   int fails;

   // Downstream bidirectional shift register fed by the sequencer.
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] exp_q;

   shift_sequencer #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_dir(in_dir), .in_len(in_len), .pause(pause),
      .sel(sel), .d0(d0), .d1(d1), .busy(busy), .done(done)
   );

   always @(posedge clk) begin
      if (!rst)                q <= '0;
      else if (sel == 2'b01)   q <= {q[WIDTH-2:0], d1};
      else if (sel == 2'b10)   q <= {d0, q[WIDTH-1:1]};
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // One transfer checked cycle by cycle against the expected bit sequence.
   // pmask[c] is the pause level for the edge ending shift-phase cycle c.
   // rst_at >= 0 pulls reset during that shift-phase cycle.
   task automatic run_xfer(input logic [3:0] data, input logic dir, input logic [2:0] len,
                           input logic [31:0] pmask, input logic junk, input int rst_at);
      logic bits[$];
      logic [3:0] m;
      int n, k;
      logic hold, fin;
      n = (len > 3'd4) ? 4 : int'(len);
      bits = {};
      for (int i = 0; i < n; i++) bits.push_back(dir ? data[n-1-i] : data[i]);
      m = data & 4'((1 << n) - 1);
`ifdef SHIFT_SEQ_PARITY_EN
      if (n > 0) bits.push_back(^m);
`endif
      in_valid = 1'b1; in_data = data; in_dir = dir; in_len = len;
      chk("ready_before_req", 32'(in_ready), 32'd1);
      step();
      in_valid = junk;
      if (junk) begin
         in_data = 4'($urandom); in_dir = 1'($urandom); in_len = 3'($urandom);
      end
      if (n == 0) begin
         in_valid = 1'b0;
         chk("len0_done", 32'(done), 32'd1);
         chk("len0_sel", 32'(sel), 32'd0);
         chk("len0_busy", 32'(busy), 32'd0);
         step();
         chk("len0_done_clr", 32'(done), 32'd0);
         chk("len0_ready", 32'(in_ready), 32'd1);
         return;
      end
      k = 0; hold = 1'b0; fin = 1'b0;
      for (int c = 0; c < 64 && !fin; c++) begin
         chk("busy", 32'(busy), 32'd1);
         chk("done_low", 32'(done), 32'd0);
         chk("ready_low", 32'(in_ready), 32'd0);
         if (hold) begin
            chk("hold_sel", 32'(sel), 32'd0);
         end else begin
            chk("sel", 32'(sel), dir ? 32'd1 : 32'd2);
            chk("bit", 32'(dir ? d1 : d0), 32'(bits[k]));
            chk("unused_line", 32'(dir ? d0 : d1), 32'd0);
            exp_q = dir ? {exp_q[2:0], bits[k]} : {bits[k], exp_q[3:1]};
            k++;
         end
         if (rst_at == c) begin
            rst = 1'b0; in_valid = 1'b0; pause = 1'b0;
            step();
            exp_q = '0;
            chk("rst_sel", 32'(sel), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_done", 32'(done), 32'd0);
            chk("rst_d0", 32'(d0), 32'd0);
            rst = 1'b1;
            step();
            chk("post_rst_done", 32'(done), 32'd0);
            chk("post_rst_ready", 32'(in_ready), 32'd1);
            return;
         end
         pause = pmask[c];
         hold  = pmask[c];
         if (!hold && k == bits.size()) fin = 1'b1;
         step();
      end
      pause = 1'b0;
      in_valid = 1'b0;
      if (!fin) begin
         chk("timeout", 32'd0, 32'd1);
         return;
      end
      chk("done", 32'(done), 32'd1);
      chk("done_sel", 32'(sel), 32'd0);
      chk("done_busy", 32'(busy), 32'd0);
      chk("done_ready", 32'(in_ready), 32'd0);
      step();
      chk("done_clr", 32'(done), 32'd0);
      chk("ready_again", 32'(in_ready), 32'd1);
      chk("q", 32'(q), 32'(exp_q));
   endtask

   initial begin
      tests = 0; fails = 0;
      exp_q = '0;
      rst = 1'b0; in_valid = 1'b0; in_data = '0; in_dir = 1'b0; in_len = '0; pause = 1'b0;
      step(); step();
      chk("rst_sel", 32'(sel), 32'd0);
      chk("rst_d0", 32'(d0), 32'd0);
      chk("rst_d1", 32'(d1), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_ready", 32'(in_ready), 32'd0);
      rst = 1'b1;
      step();
      chk("ready_after_rst", 32'(in_ready), 32'd1);

      run_xfer(4'b1011, 1'b0, 3'd4, 32'h0, 1'b0, -1);   // right, full
      run_xfer(4'b1011, 1'b1, 3'd4, 32'h0, 1'b0, -1);   // left, full
      run_xfer(4'b1011, 1'b0, 3'd0, 32'h0, 1'b0, -1);   // zero length
      run_xfer(4'b0110, 1'b0, 3'd7, 32'h0, 1'b1, -1);   // clamped length
      run_xfer(4'b1110, 1'b1, 3'd2, 32'h0, 1'b0, -1);   // partial left
      run_xfer(4'b1011, 1'b0, 3'd4, 32'h6, 1'b0, -1);   // pause after 2nd bit
      run_xfer(4'b0101, 1'b1, 3'd4, 32'h8, 1'b1, -1);   // pause on last bit
      run_xfer(4'b1011, 1'b0, 3'd4, 32'h0, 1'b0, 2);    // reset mid-transfer
      run_xfer(4'b1001, 1'b0, 3'd4, 32'h0, 1'b0, -1);   // normal after reset

      for (int r = 0; r < 30; r++) begin
         run_xfer(4'($urandom), 1'($urandom), 3'($urandom_range(0, 7)),
                  $urandom & $urandom & $urandom, 1'($urandom), -1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
